// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM read arbiter: requester index, response tag and lock counter.
package sram_arb_pkg;

  localparam int unsigned MAX_REQ = 4;

  typedef logic [1:0] req_idx_t;
  typedef logic [7:0] lock_cnt_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } tag_t;

  typedef enum logic {
    StIdleRr,
    StLocked
  } arb_state_e;

  function automatic req_idx_t rr_next(input req_idx_t i, input int unsigned n);
    return req_idx_t'((32'(i) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Requester-side bundle of the SRAM read arbiter: requests in, grants and tagged responses out.
interface sram_read_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_addr, req_lock,
    input  req_grant, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_lock,
    output req_grant, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_idx_t           ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output req_idx_t           idx_o,
  output logic               any_o
);

  req_idx_t cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = req_idx_t'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin read arbiter for one registered-read SRAM port, with bounded lock bursts
// and per-requester response tagging aligned to the SRAM read latency.
module sram_read_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_LOCK     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_read_arbiter_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] sram_read_address_o,
  input  logic [DATA_WIDTH-1:0] sram_read_data_i,
  output logic                  busy_o
);

  arb_state_e            state_q, state_d;
  req_idx_t              owner_q, owner_d;
  req_idx_t              ptr_q, ptr_d;
  lock_cnt_t             cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] addr_q, gnt_addr;
  tag_t                  tag_q [READ_LATENCY];

  logic [NUM_REQ-1:0] rr_gnt, gnt, rsp_valid;
  req_idx_t           rr_idx, gnt_idx;
  logic               rr_any, owner_hit, accept, in_flight;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i(bus.req_valid),
    .ptr_i(ptr_q),
    .gnt_o(rr_gnt),
    .idx_o(rr_idx),
    .any_o(rr_any)
  );

  assign owner_hit = (state_q == StLocked) && bus.req_valid[owner_q];

  // A live owner pre-empts round-robin; nothing is granted while reset is asserted.
  always_comb begin
    gnt     = '0;
    gnt_idx = rr_idx;
    accept  = 1'b0;
    if (!reset) begin
      if (owner_hit) begin
        gnt[owner_q] = 1'b1;
        gnt_idx      = owner_q;
        accept       = 1'b1;
      end else if (rr_any) begin
        gnt    = rr_gnt;
        accept = 1'b1;
      end
    end
  end

  assign bus.req_grant = gnt;

  always_comb begin
    gnt_addr = addr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && gnt_idx == req_idx_t'(i)) begin
        gnt_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign sram_read_address_o = gnt_addr;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cnt_inc = (owner_hit ? cnt_q : lock_cnt_t'(0)) + lock_cnt_t'(1);
    if (state_q == StLocked && !bus.req_valid[owner_q]) begin
      state_d = StIdleRr;
      cnt_d   = '0;
    end
    if (accept) begin
      if (!owner_hit) begin
        ptr_d = rr_next(gnt_idx, NUM_REQ);
      end
      if (bus.req_lock[gnt_idx]) begin
        if (cnt_inc >= lock_cnt_t'(MAX_LOCK)) begin
          // Lock budget spent: hand priority to the requester after the owner.
          state_d = StIdleRr;
          cnt_d   = '0;
          ptr_d   = rr_next(gnt_idx, NUM_REQ);
        end else begin
          state_d = StLocked;
          owner_d = gnt_idx;
          cnt_d   = cnt_inc;
        end
      end else begin
        state_d = StIdleRr;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdleRr;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= gnt_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: accept, idx: gnt_idx};
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[READ_LATENCY-1].valid && (tag_q[READ_LATENCY-1].idx == req_idx_t'(i));
    end
  end

  always_comb begin
    in_flight = 1'b0;
    for (int unsigned s = 0; s < READ_LATENCY; s++) begin
      in_flight = in_flight | tag_q[s].valid;
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = sram_read_data_i;
  assign busy_o        = (|bus.req_valid) | in_flight;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: two instances (latency 1 / lock 4, latency 2 / lock 16) share
// stimulus and are checked every cycle against a queue-based arbitration model.
module tb_sram_read_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  typedef struct {
    bit          v;
    int          idx;
    logic [11:0] a;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    valid = '0;
  logic [3:0]    lock = '0;
  logic [47:0]   addr = '0;
  logic [11:0]   sa0, sa1;
  logic [15:0]   sd0, rd1a, sd1;
  logic          busy0, busy1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int          m_ptr   [2];
  int          m_owner [2];
  int          m_cnt   [2];
  logic [11:0] m_last  [2];
  exp_t        pend    [2][8];

  sram_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  sram_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.req_valid = valid;
  assign bus0.req_lock  = lock;
  assign bus0.req_addr  = addr;
  assign bus1.req_valid = valid;
  assign bus1.req_lock  = lock;
  assign bus1.req_addr  = addr;

  sram_read_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .MAX_LOCK(4)
  ) u_dut0 (
    .clk(clk),
    .reset(reset),
    .bus(bus0),
    .sram_read_address_o(sa0),
    .sram_read_data_i(sd0),
    .busy_o(busy0)
  );

  sram_read_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .MAX_LOCK(16)
  ) u_dut1 (
    .clk(clk),
    .reset(reset),
    .bus(bus1),
    .sram_read_address_o(sa1),
    .sram_read_data_i(sd1),
    .busy_o(busy1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [11:0] a);
    if (a == 12'h005) return 16'hABCD;
    return {a[3:0] ^ 4'h5, a};
  endfunction

  function automatic int rl_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int ml_of(input int i);
    return (i == 0) ? 4 : 16;
  endfunction

  // SRAM contents are a fixed function of the address; registered read of 1 or 2 cycles.
  always @(posedge clk) begin
    sd0  <= word(sa0);
    rd1a <= word(sa1);
    sd1  <= rd1a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0]  a_g, a_r, e_g, e_r;
    logic [11:0] a_a, e_a;
    logic [15:0] a_d;
    logic        a_b, e_b;
    int          g, slot;
    bit          fl;
    slot = cyc % 8;
    for (int i = 0; i < 2; i++) begin
      a_g = (i == 0) ? bus0.req_grant : bus1.req_grant;
      a_r = (i == 0) ? bus0.rsp_valid : bus1.rsp_valid;
      a_d = (i == 0) ? bus0.rsp_data : bus1.rsp_data;
      a_a = (i == 0) ? sa0 : sa1;
      a_b = (i == 0) ? busy0 : busy1;
      g   = -1;
      if (reset) begin
        m_ptr[i]   = 0;
        m_owner[i] = -1;
        m_cnt[i]   = 0;
        m_last[i]  = '0;
        for (int s = 0; s < 8; s++) pend[i][s].v = 1'b0;
        e_g = '0;
        e_r = '0;
        e_a = '0;
        e_b = |valid;
      end else begin
        if (m_owner[i] >= 0 && valid[m_owner[i]]) g = m_owner[i];
        else begin
          for (int k = 0; k < 4; k++) begin
            if (g < 0 && valid[(m_ptr[i] + k) % 4]) g = (m_ptr[i] + k) % 4;
          end
        end
        e_g = (g >= 0) ? 4'(1 << g) : 4'd0;
        e_a = (g >= 0) ? addr[g*12 +: 12] : m_last[i];
        e_r = pend[i][slot].v ? 4'(1 << pend[i][slot].idx) : 4'd0;
        fl  = 1'b0;
        for (int s = 0; s < 8; s++) fl = fl | pend[i][s].v;
        e_b = (|valid) | fl;
      end
      chk($sformatf("u%0d.grant", i), 32'(a_g), 32'(e_g));
      chk($sformatf("u%0d.rsp_valid", i), 32'(a_r), 32'(e_r));
      chk($sformatf("u%0d.address", i), 32'(a_a), 32'(e_a));
      chk($sformatf("u%0d.busy", i), 32'(a_b), 32'(e_b));
      if (e_r != 4'd0) chk($sformatf("u%0d.rsp_data", i), 32'(a_d), 32'(word(pend[i][slot].a)));
      if (!reset) begin
        pend[i][slot].v = 1'b0;
        if (m_owner[i] >= 0 && !valid[m_owner[i]]) begin
          m_owner[i] = -1;
          m_cnt[i]   = 0;
        end
        if (g >= 0) begin
          m_last[i] = addr[g*12 +: 12];
          pend[i][(cyc + rl_of(i)) % 8] = '{v: 1'b1, idx: g, a: m_last[i]};
          if (g != m_owner[i]) m_ptr[i] = (g + 1) % 4;
          if (lock[g]) begin
            m_cnt[i] = ((g == m_owner[i]) ? m_cnt[i] : 0) + 1;
            if (m_cnt[i] >= ml_of(i)) begin
              m_owner[i] = -1;
              m_cnt[i]   = 0;
              m_ptr[i]   = (g + 1) % 4;
            end else begin
              m_owner[i] = g;
            end
          end else begin
            m_owner[i] = -1;
            m_cnt[i]   = 0;
          end
        end
      end
    end
    cyc++;
  end

  // Drive one cycle of requests just after the edge; optionally pin u_dut0's grant mid-cycle.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input bit do_chk,
                      input logic [3:0] g0);
    @(posedge clk);
    #1;
    valid = v;
    lock  = l;
    @(negedge clk);
    if (do_chk) chk("lit.grant", 32'(bus0.req_grant), 32'(g0));
  endtask

  logic [3:0] lock_seq [7];

  initial begin
    lock_seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    addr = {12'h333, 12'h222, 12'h111, 12'h005};
    repeat (3) @(negedge clk);
    chk("lit.reset.grant", 32'(bus0.req_grant), 32'd0);
    chk("lit.reset.rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("lit.reset.busy", 32'(busy0), 32'd0);
    chk("lit.reset.address", 32'(sa1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single requester, latency 1
    step(4'b0001, 4'b0000, 1'b1, 4'b0001);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("lit.single.rsp_valid", 32'(bus0.rsp_valid), 32'h1);
    chk("lit.single.rsp_data", 32'(bus0.rsp_data), 32'hABCD);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Round-robin fairness; a grant to 3 first puts the pointer back at 0
    step(4'b1000, 4'b0000, 1'b1, 4'b1000);
    for (int k = 0; k < 8; k++) step(4'b1111, 4'b0000, 1'b1, 4'b0001 << (k % 4));

    // Lock with forced release after four grants; grant to 1 first puts the pointer at 2
    step(4'b0010, 4'b0000, 1'b1, 4'b0010);
    for (int k = 0; k < 7; k++) step(4'b1111, 4'b0100, 1'b1, lock_seq[k]);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Owner drops valid mid-lock
    step(4'b0001, 4'b0001, 1'b1, 4'b0001);
    step(4'b0111, 4'b0001, 1'b1, 4'b0001);
    step(4'b0110, 4'b0001, 1'b1, 4'b0010);
    step(4'b0111, 4'b0000, 1'b1, 4'b0100);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    addr[23:12] = 12'h08F;

    // Reset one cycle after accepting requester 1
    step(4'b0010, 4'b0000, 1'b1, 4'b0010);
    @(posedge clk);
    #1;
    valid = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    chk("lit.rst.rsp_valid0", 32'(bus0.rsp_valid), 32'd0);
    chk("lit.rst.rsp_valid1", 32'(bus1.rsp_valid), 32'd0);
    chk("lit.rst.busy1", 32'(busy1), 32'd0);
    chk("lit.rst.address0", 32'(sa0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("lit.rst.after.rsp_valid1", 32'(bus1.rsp_valid), 32'd0);
    addr[11:0]  = 12'h123;
    addr[23:12] = 12'h456;

    // Back-to-back reads through the latency-2 instance
    step(4'b0001, 4'b0000, 1'b1, 4'b0001);
    step(4'b0010, 4'b0000, 1'b1, 4'b0010);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("lit.rl2.rsp_valid.a", 32'(bus1.rsp_valid), 32'h1);
    chk("lit.rl2.rsp_data.a", 32'(bus1.rsp_data), 32'h6123);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("lit.rl2.rsp_valid.b", 32'(bus1.rsp_valid), 32'h2);
    chk("lit.rl2.rsp_data.b", 32'(bus1.rsp_data), 32'h3456);
    repeat (3) step(4'b0000, 4'b0000, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
